// File: rtl/layer_argmax_stage.sv
// Argmax over one frame of M signed activations; reports index and value of the largest (ties keep earliest).
// Latency: result valid the cycle after the M-th accepted word; min frame period M+1 cycles.
// Backpressure: s_ready low outside COLLECT; result held stable in EMIT until m_ready, no new words taken meanwhile.
module layer_argmax_stage #(
    parameter int M    = 8,
    parameter int T    = 20,
    parameter int LOGM = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic signed [T-1:0]   data_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [LOGM-1:0]       max_index,
    output logic signed [T-1:0]   max_value,
    output logic [7:0]            frame_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    localparam logic [LOGM:0] LAST_ELEM = (LOGM+1)'(M - 1);
    localparam logic [LOGM:0] ELEM_ONE  = (LOGM+1)'(1);

    state_t                 state_q, state_d;
    logic [LOGM:0]          elem_q, elem_d;
    logic signed [T-1:0]    best_val_q, best_val_d;
    logic [LOGM-1:0]        best_idx_q, best_idx_d;
    logic [7:0]             frame_cnt_q, frame_cnt_d;

    // Next-state and handshake decode; s_ready/m_valid depend only on the state register.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        frame_cnt_d = frame_cnt_q;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = COLLECT;
            end
            COLLECT: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    // First word of a frame seeds the running best unconditionally;
                    // later words replace it only when strictly larger, so ties keep the lower index.
                    if (elem_q == '0) begin
                        best_val_d = data_in;
                        best_idx_d = '0;
                    end else if (data_in > best_val_q) begin
                        best_val_d = data_in;
                        best_idx_d = elem_q[LOGM-1:0];
                    end
                    if (elem_q == LAST_ELEM) begin
                        elem_d  = '0;
                        state_d = EMIT;
                    end else begin
                        elem_d = elem_q + ELEM_ONE;
                    end
                end
            end
            EMIT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d     = COLLECT;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial frame and the frame count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            elem_q      <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Results are the running-best registers themselves, so they persist after EMIT.
    assign max_index = best_idx_q;
    assign max_value = best_val_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_layer_argmax_stage.sv
module tb_layer_argmax_stage;

    localparam int M    = 8;
    localparam int T    = 20;
    localparam int LOGM = 3;

    logic                 clk;
    logic                 reset;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [T-1:0]  data_in;
    logic                 m_valid;
    logic                 m_ready;
    logic [LOGM-1:0]      max_index;
    logic signed [T-1:0]  max_value;
    logic [7:0]           frame_cnt;

    int n_cmp;
    int n_bad;
    int cyc;
    int fr[8];

    layer_argmax_stage #(.M(M), .T(T), .LOGM(LOGM)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .data_in   (data_in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .max_index (max_index),
        .max_value (max_value),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one word and wait (bounded) for it to be accepted; returns #1 after the accept edge.
    task automatic send_word(input int w);
        bit acc;
        bit done;
        done = 1'b0;
        s_valid = 1'b1;
        data_in = T'(w);
        for (int n = 0; n < 50 && !done; n++) begin
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (acc) done = 1'b1;
        end
        s_valid = 1'b0;
        if (!done) check_val("accept_timeout", 0, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send a frame; maxgap>0 inserts 1..maxgap idle cycles between words.
    // With hold=1 the EMIT handshake is left to the caller.
    task automatic run_frame(input string tag, input int w[8], input int maxgap,
                             input int eidx, input int eval, input int ecnt, input bit hold);
        for (int i = 0; i < M; i++) begin
            send_word(w[i]);
            if (i == M - 2) check_val({tag, "_mvalid_early"}, m_valid, 0);
            if (i < M - 1 && maxgap > 0) idle_cycles($urandom_range(maxgap, 1));
        end
        check_val({tag, "_mvalid"}, m_valid, 1);
        check_val({tag, "_sready_emit"}, s_ready, 0);
        check_val({tag, "_idx"}, max_index, eidx);
        check_val({tag, "_val"}, max_value, eval);
        if (!hold) begin
            @(posedge clk);
            #1;
            check_val({tag, "_mvalid_drop"}, m_valid, 0);
            check_val({tag, "_sready_back"}, s_ready, 1);
            check_val({tag, "_cnt"}, frame_cnt, ecnt);
            check_val({tag, "_val_kept"}, max_value, eval);
        end
    endtask

    initial begin
        int t0;
        n_cmp   = 0;
        n_bad   = 0;
        cyc     = 0;
        reset   = 1'b1;
        s_valid = 1'b0;
        data_in = '0;
        m_ready = 1'b1;

        #2;
        check_val("rst_sready", s_ready, 0);
        check_val("rst_mvalid", m_valid, 0);
        check_val("rst_idx", max_index, 0);
        check_val("rst_val", max_value, 0);
        check_val("rst_cnt", frame_cnt, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("idle_sready", s_ready, 0);
        @(posedge clk);
        #1;
        check_val("collect_sready", s_ready, 1);

        // Ascending frame, s_valid held high: 8 accepts in 8 cycles.
        fr = '{10, 20, 30, 40, 50, 60, 70, 80};
        t0 = cyc;
        run_frame("asc", fr, 0, 7, 80, 1, 1'b0);
        check_val("asc_cycles", cyc - t0, M + 1);

        fr = '{5, -3, 90, 12, 90, 0, 90, 1};
        run_frame("tie", fr, 0, 2, 90, 2, 1'b0);

        fr = '{-7, -2, -524288, -2, -9, -100, -50, -3};
        run_frame("neg", fr, 0, 1, -2, 3, 1'b0);

        fr = '{0, 0, 0, 0, 0, 0, 524287, -524288};
        run_frame("maxpos", fr, 0, 6, 524287, 4, 1'b0);

        // Backpressure in EMIT with the next word already presented.
        m_ready = 1'b0;
        fr = '{1, 2, 3, 100, 4, 5, 6, 7};
        run_frame("bp", fr, 0, 3, 100, 5, 1'b1);
        s_valid = 1'b1;
        data_in = T'(33);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_val("bp_hold_mvalid", m_valid, 1);
            check_val("bp_hold_sready", s_ready, 0);
            check_val("bp_hold_idx", max_index, 3);
            check_val("bp_hold_val", max_value, 100);
            check_val("bp_hold_cnt", frame_cnt, 4);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_release_mvalid", m_valid, 0);
        check_val("bp_release_sready", s_ready, 1);
        check_val("bp_release_cnt", frame_cnt, 5);
        check_val("bp_release_val", max_value, 100);
        fr = '{33, 1, 2, 3, 4, 5, 6, 7};
        run_frame("held", fr, 0, 0, 33, 6, 1'b0);

        // Fresh start, then three frames with random gaps between words.
        reset = 1'b1;
        #1;
        check_val("rst2_cnt", frame_cnt, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        fr = '{3, -1, 7, 7, 2, -8, 0, 6};
        run_frame("gap1", fr, 4, 2, 7, 1, 1'b0);
        fr = '{-5, -5, -5, -5, -5, -5, -5, -5};
        run_frame("gap2", fr, 4, 0, -5, 2, 1'b0);
        fr = '{100, -200, 50, 99, 101, 101, -300, 0};
        run_frame("gap3", fr, 4, 4, 101, 3, 1'b0);

        // Asynchronous reset mid-frame after four accepts.
        send_word(1000);
        send_word(2);
        send_word(3);
        send_word(4);
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_rst_val", max_value, 0);
        check_val("mid_rst_idx", max_index, 0);
        check_val("mid_rst_cnt", frame_cnt, 0);
        check_val("mid_rst_sready", s_ready, 0);
        check_val("mid_rst_mvalid", m_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        fr = '{1, 2, 3, 4, 5, 6, 7, 8};
        run_frame("after_rst", fr, 0, 7, 8, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
